// File: rtl/alu_result_display.sv
// Captures the ALU's 8-bit result over valid/ready and shows it on one 7-segment digit
// as a repeating frame: high nibble with decimal point, blank, low nibble, blank.
module alu_result_display #(
  parameter int DWELL_CYCLES = 10000000,
  parameter int GAP_CYCLES   = 2000000,
  parameter int CNT_W        = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] result_in,
  input  logic       result_valid,
  output logic       result_ready,
  input  logic       clear,
  output logic [7:0] seg_out,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HI    = 3'd1,
    GAP_H = 3'd2,
    LO    = 3'd3,
    GAP_L = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [7:0]       shown_reg, shown_next;
  logic [7:0]       pending_reg, pending_next;
  logic             pending_v_reg, pending_v_next;
  logic [7:0]       seg_reg, seg_next;
  logic             take;

  function automatic logic [6:0] hex_font(input logic [3:0] d);
    logic [6:0] f;
    case (d)
      4'h0: f = 7'h3F;
      4'h1: f = 7'h06;
      4'h2: f = 7'h5B;
      4'h3: f = 7'h4F;
      4'h4: f = 7'h66;
      4'h5: f = 7'h6D;
      4'h6: f = 7'h7D;
      4'h7: f = 7'h07;
      4'h8: f = 7'h7F;
      4'h9: f = 7'h6F;
      4'hA: f = 7'h77;
      4'hB: f = 7'h7C;
      4'hC: f = 7'h39;
      4'hD: f = 7'h5E;
      4'hE: f = 7'h79;
      default: f = 7'h71;
    endcase
    return f;
  endfunction

  // Segment pattern is derived from the upcoming state so the display flips on the same edge.
  function automatic logic [7:0] seg_encode(input state_t st, input logic [7:0] val);
    logic [7:0] s;
    case (st)
      HI:      s = {1'b1, hex_font(val[7:4])};
      LO:      s = {1'b0, hex_font(val[3:0])};
      default: s = 8'h00;
    endcase
    return s;
  endfunction

  assign result_ready = ena & ~pending_v_reg & ~clear;
  assign take         = result_valid & result_ready;
  assign busy         = (state_reg != IDLE);
  assign seg_out      = seg_reg;

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    shown_next     = shown_reg;
    pending_next   = pending_reg;
    pending_v_next = pending_v_reg;
    seg_next       = seg_reg;

    if (clear) begin
      state_next     = IDLE;
      pending_v_next = 1'b0;
      cnt_next       = '0;
      seg_next       = 8'h00;
    end else if (ena) begin
      // take implies an empty buffer, so it never collides with a consume below
      if (take) begin
        pending_next   = result_in;
        pending_v_next = 1'b1;
      end
      case (state_reg)
        IDLE: begin
          if (pending_v_reg) begin
            state_next     = HI;
            shown_next     = pending_reg;
            pending_v_next = 1'b0;
            cnt_next       = '0;
          end
        end
        HI: begin
          if (cnt_reg == DWELL_LAST) begin
            state_next = GAP_H;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + CNT_ONE;
          end
        end
        GAP_H: begin
          if (cnt_reg == GAP_LAST) begin
            state_next = LO;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + CNT_ONE;
          end
        end
        LO: begin
          if (cnt_reg == DWELL_LAST) begin
            state_next = GAP_L;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + CNT_ONE;
          end
        end
        GAP_L: begin
          if (cnt_reg == GAP_LAST) begin
            state_next = HI;
            cnt_next   = '0;
            if (pending_v_reg) begin
              shown_next     = pending_reg;
              pending_v_next = 1'b0;
            end
          end else begin
            cnt_next = cnt_reg + CNT_ONE;
          end
        end
        default: begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      endcase
      seg_next = seg_encode(state_next, shown_next);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      shown_reg     <= 8'h00;
      pending_reg   <= 8'h00;
      pending_v_reg <= 1'b0;
      seg_reg       <= 8'h00;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      shown_reg     <= shown_next;
      pending_reg   <= pending_next;
      pending_v_reg <= pending_v_next;
      seg_reg       <= seg_next;
    end
  end

endmodule

// File: tb/tb_alu_result_display.sv
// Scoreboarded bench for alu_result_display with short dwell/gap so whole frames are checked.
module tb_alu_result_display;

  localparam int DWELL = 4;
  localparam int GAP   = 2;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] result_in;
  logic       result_valid;
  logic       result_ready;
  logic       clear;
  logic [7:0] seg_out;
  logic       busy;

  int total_cnt = 0;
  int bad_cnt   = 0;

  alu_result_display #(
    .DWELL_CYCLES(DWELL),
    .GAP_CYCLES  (GAP),
    .CNT_W       (3)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .result_in   (result_in),
    .result_valid(result_valid),
    .result_ready(result_ready),
    .clear       (clear),
    .seg_out     (seg_out),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end else begin
      $display("ok   %s: %0h at %0t", tag, got, $time);
    end
  endtask

  function automatic logic [7:0] font(input logic [3:0] d);
    logic [7:0] f;
    case (d)
      4'h0: f = 8'h3F;  4'h1: f = 8'h06;  4'h2: f = 8'h5B;  4'h3: f = 8'h4F;
      4'h4: f = 8'h66;  4'h5: f = 8'h6D;  4'h6: f = 8'h7D;  4'h7: f = 8'h07;
      4'h8: f = 8'h7F;  4'h9: f = 8'h6F;  4'hA: f = 8'h77;  4'hB: f = 8'h7C;
      4'hC: f = 8'h39;  4'hD: f = 8'h5E;  4'hE: f = 8'h79;  default: f = 8'h71;
    endcase
    return f;
  endfunction

  // Scoreboard: accepted values with the edge that accepted them; a frame start
  // takes the oldest value accepted strictly before that frame's first edge.
  typedef struct {
    logic [7:0] val;
    int         edge_no;
  } acc_t;

  acc_t       sb_q[$];
  int         edge_no   = 0;
  int         run_len   = 0;
  logic       run_busy  = 1'b0;
  logic [7:0] prev_seg  = 8'h00;
  logic [7:0] cur_val   = 8'h00;
  logic       ena_l     = 1'b0;
  logic       clr_l     = 1'b0;
  logic       acc_l     = 1'b0;
  logic [7:0] acc_val_l = 8'h00;

  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
      run_len  = 0;
      run_busy = 1'b0;
      prev_seg = 8'h00;
      ena_l    = 1'b0;
      clr_l    = 1'b0;
      acc_l    = 1'b0;
    end else begin
      edge_no++;
      if (acc_l) sb_q.push_back('{acc_val_l, edge_no});
      if (clr_l) begin
        sb_q.delete();
        run_len  = 0;
        run_busy = 1'b0;
        prev_seg = seg_out;
      end else if (ena_l) begin
        if (seg_out == prev_seg) begin
          run_len++;
        end else begin
          if (run_busy && run_len > 0) begin
            if (prev_seg == 8'h00) check_val("gap_len", run_len, GAP);
            else                   check_val("dwell_len", run_len, DWELL);
          end
          if (seg_out[7] && prev_seg == 8'h00) begin
            if (sb_q.size() > 0 && sb_q[0].edge_no < edge_no) cur_val = sb_q.pop_front().val;
            check_val("hi_digit", seg_out, font(cur_val[7:4]) | 8'h80);
          end else if (seg_out != 8'h00) begin
            check_val("lo_digit", seg_out, font(cur_val[3:0]));
          end
          run_len  = 1;
          run_busy = busy;
          prev_seg = seg_out;
        end
      end
      ena_l     = ena;
      clr_l     = clear;
      acc_l     = result_valid && result_ready;
      acc_val_l = result_in;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds valid until the block is ready, then lets one edge transfer it.
  task automatic send(input logic [7:0] v, output int waited);
    waited       = 0;
    result_in    = v;
    result_valid = 1'b1;
    while (!result_ready && waited < 200) begin
      tick();
      waited++;
    end
    if (!result_ready) check_val("send_timeout", 0, 1);
    tick();
    result_valid = 1'b0;
  endtask

  task automatic wait_lo(input string tag);
    int n;
    n = 0;
    while (!(seg_out != 8'h00 && !seg_out[7]) && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) check_val(tag, 0, 1);
  endtask

  task automatic wait_seg(input string tag, input logic [7:0] v);
    int n;
    n = 0;
    while (seg_out != v && n < 100) begin
      tick();
      n++;
    end
    check_val(tag, seg_out, v);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int n;
    rst_n        = 1'b0;
    ena          = 1'b1;
    result_in    = 8'h00;
    result_valid = 1'b0;
    clear        = 1'b0;
    repeat (3) tick();
    check_val("rst_seg", seg_out, 8'h00);
    check_val("rst_busy", busy, 0);
    check_val("rst_ready", result_ready, 1);
    rst_n = 1'b1;
    repeat (2) tick();

    // first value: blank one edge after accept, high digit the edge after
    send(8'hA7, w);
    check_val("a7_ready_low", result_ready, 0);
    check_val("a7_latency_blank", seg_out, 8'h00);
    tick();
    check_val("a7_hi", seg_out, 8'hF7);
    check_val("a7_busy", busy, 1);
    wait_lo("a7_wait_lo");
    check_val("a7_lo", seg_out, 8'h07);
    wait_seg("a7_repeat_hi", 8'hF7);

    // mid-HI second result; ready comes back only at the frame boundary
    tick();
    send(8'h3C, w);
    check_val("3c_ready_low", result_ready, 0);
    n = 0;
    while (!result_ready && n < 100) begin
      tick();
      n++;
    end
    check_val("3c_ready_back", result_ready, 1);
    check_val("3c_hi_at_boundary", seg_out, 8'hCF);

    // occupy pending, then a held 55 must stall until the next boundary
    send(8'h99, w);
    send(8'h55, w);
    check_val("55_stalled", (w > 0) ? 1 : 0, 1);
    wait_seg("55_shown", 8'hED);

    // clear during LO with valid high drops the value
    wait_lo("clr_wait_lo");
    clear        = 1'b1;
    result_valid = 1'b1;
    result_in    = 8'h66;
    #1;
    check_val("clr_ready_low", result_ready, 0);
    tick();
    clear        = 1'b0;
    result_valid = 1'b0;
    check_val("clr_seg", seg_out, 8'h00);
    check_val("clr_busy", busy, 0);
    repeat (3) tick();
    check_val("clr_no_capture", busy, 0);
    send(8'h00, w);
    tick();
    check_val("00_hi", seg_out, 8'hBF);
    wait_lo("00_wait_lo");
    check_val("00_lo", seg_out, 8'h3F);

    // freeze in GAP_H right after it is entered
    wait_seg("frz_hi", 8'hBF);
    wait_seg("frz_gap", 8'h00);
    ena = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_val("frz_seg", seg_out, 8'h00);
    end
    check_val("frz_ready", result_ready, 0);
    ena = 1'b1;
    n   = 0;
    do begin
      tick();
      n++;
    end while (seg_out == 8'h00 && n < 20);
    check_val("frz_remaining_gap", n, GAP);
    check_val("frz_lo", seg_out, 8'h3F);

    // asynchronous reset mid-frame
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_val("arst_seg", seg_out, 8'h00);
    check_val("arst_busy", busy, 0);
    tick();
    rst_n = 1'b1;
    check_val("arst_ready", result_ready, 1);
    check_val("arst_idle", busy, 0);
    send(8'h5A, w);
    tick();
    check_val("5a_hi", seg_out, 8'hED);
    wait_lo("5a_wait_lo");
    check_val("5a_lo", seg_out, 8'h77);
    repeat (16) tick();
    check_val("sb_empty", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule

// File: doc/alu_result_display.md
Name: alu_result_display

Overview:
- Downstream stage of the 4-bit ALU. Captures the ALU's 8-bit result through a valid/ready handshake.
- Presents the result on the single 7-segment display (uo_out) as a timed sequence: high hex digit, blank, low hex digit, blank, repeating.
- The decimal point marks the high digit, so an 8-bit value is readable on one digit. A new result is swapped in only at a frame boundary, so a digit pair is never torn.

Parameters:
- DWELL_CYCLES, 10000000, cycles each digit is shown (>=1).
- GAP_CYCLES, 2000000, cycles of blank after each digit (>=1).
- CNT_W, 24, phase counter width; must hold max(DWELL_CYCLES, GAP_CYCLES)-1.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset; one clock, reset asynchronous and active-low.
- ena  input  1  design enable; low freezes FSM and counter and blocks capture.
- result_in  input  8  ALU result to display.
- result_valid  input  1  result_in valid this cycle.
- result_ready  output  1  block can accept result_in this cycle.
- clear  input  1  synchronous clear to IDLE, blank display.
- seg_out  output  8  [6:0] segments gfedcba active-high, [7] decimal point; drives uo_out.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (rst_n=0, async): state=IDLE, seg_out=8'h00, busy=0, shown=8'h00, pending_v=0, counter=0. result_ready reflects the combinational rule below (1 when ena=1).
- result_ready = ena & ~pending_v & ~clear (combinational). Transfer occurs on an edge where result_valid & result_ready: pending<=result_in, pending_v<=1.
- States: IDLE, HI, GAP_H, LO, GAP_L.
- IDLE: seg_out=0. On an edge with ena & pending_v: go to HI, shown<=pending, pending_v<=0, counter<=0.
- HI: shows hex(shown[7:4]) with dp=1, for exactly DWELL_CYCLES cycles, then GAP_H.
- GAP_H: seg_out=0 for GAP_CYCLES cycles, then LO.
- LO: shows hex(shown[3:0]) with dp=0, for DWELL_CYCLES cycles, then GAP_L.
- GAP_L: seg_out=0 for GAP_CYCLES cycles, then HI (frame boundary). At this transition, if pending_v then shown<=pending and pending_v<=0; otherwise shown is unchanged. The display loops indefinitely.
- Counter counts 0..N-1 within a phase and resets to 0 on every state change.
- seg_out is registered and computed from next-state and next-shown, so it changes on the same edge as the state.
- Latency: valid accepted at edge N in IDLE -> high digit visible after edge N+1.
- Hex font (gfedcba), 0..F: 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71.
- ena=0: state, counter, shown, pending and seg_out hold; no capture.
- clear=1 (sampled on edge, requires no ena): state<=IDLE, pending_v<=0, counter<=0, seg_out<=0; shown is retained. clear has priority over a simultaneous valid, and that value is dropped (ready is low).
- A single-entry pending buffer holds the result; a second result stalls on ready=0 until the frame boundary frees the buffer.
- Reset asserted mid-frame: immediate blank and IDLE, regardless of clock.

Test Plan (DWELL_CYCLES=4, GAP_CYCLES=2):
- Reset then result_in=8'hA7, valid for 1 cycle -> next edge state=HI, seg_out=8'hF7 (A+dp) for 4 cycles; 00 for 2; 8'h07 for 4; 00 for 2; then repeats 8'hF7.
- Mid-HI of 8'hA7, send 8'h3C -> ready drops after accept; display finishes A,7 frame; next frame shows 8'hCF (3+dp) then 8'h39; ready returns high at that boundary.
- With pending occupied, hold valid with 8'h55 -> ready=0, no capture until boundary; then accepted; 8'h55 shown the following frame.
- Assert clear during LO with valid high -> next edge seg_out=00, busy=0, valid value not captured; a later valid of 8'h00 shows 8'hBF then 8'h3F.
- ena=0 for 5 cycles mid-GAP_H -> seg_out and counter frozen; after ena=1, the remaining gap cycles complete before LO.
- rst_n low asynchronously mid-frame -> seg_out=00 without a clock edge; after release, ready=1 and state IDLE.
